// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and helpers for the byte-wide RAM/IO responder.
// IO window lives at 0x30000; only address bits 17:0 are decoded.
package mem_bus_responder_pkg;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] IO_OUT  = 32'h0003_0000;
  localparam logic [31:0] IO_HALT = 32'h0003_0004;

  localparam int unsigned RAM_ADDR_W_DEF = 17;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned FIFO_PTR_W_DEF = 3;

  typedef enum logic [2:0] {
    ACC_NONE   = 3'd0,
    ACC_RAM_RD = 3'd1,
    ACC_RAM_WR = 3'd2,
    ACC_IO_RD  = 3'd3,
    ACC_IO_WR  = 3'd4
  } acc_e;

  // Read value of an IO register; only the halt status reads back non-zero.
  function automatic logic [7:0] io_read_data(input logic [17:0] off, input logic halt);
    logic [7:0] data;
    case ({14'd0, off})
      IO_HALT: data = {7'd0, halt};
      default: data = 8'h00;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/mem_bus_responder_byte_fifo.sv
// Circular byte FIFO with combinational head, count and a registered
// almost-full flag that leaves one slot of headroom.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             almost_full,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_LVL   = (PTR_W+1)'(DEPTH - 1);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_nxt_s;
  logic             almost_full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full        = (count_r == FULL_LVL);
  assign pop_ok_s    = pop && (count_r != '0);
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok_s   = push && (!full || pop_ok_s);
  assign dout        = (count_r == '0) ? 8'h00 : mem_r[rd_ptr_r];
  assign count       = count_r;
  assign almost_full = almost_full_r;

  // Next occupancy from this cycle's accepted push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage write; contents need no reset because count gates the head.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and almost-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      almost_full_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r       <= count_nxt_s;
      almost_full_r <= (count_nxt_s >= AF_LVL);
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: 128 KiB byte RAM with registered read data, plus an
// IO window at 0x30000 holding a TX byte FIFO and a sticky halt flag.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = RAM_ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned FIFO_PTR_W = FIFO_PTR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  input  logic [31:0]           mem_a,
  input  logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic                  load_en,
  input  logic [RAM_ADDR_W-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic                  io_buffer_full,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  halt,
  output logic                  overflow
);

  logic [7:0]            ram_r [0:(1 << RAM_ADDR_W) - 1];
  logic [RAM_ADDR_W-1:0] ram_idx_s;
  logic [31:0]           io_addr_s;
  logic                  io_sel_s;
  logic                  unused_a_s;
  acc_e                  acc_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic [FIFO_PTR_W:0]   fifo_count_s;
  logic [7:0]            mem_dout_r;
  logic                  halt_r;
  logic                  overflow_r;

  assign ram_idx_s  = mem_a[RAM_ADDR_W-1:0];
  assign io_addr_s  = {14'd0, mem_a[17:0]};
  assign io_sel_s   = (mem_a[17:16] == IO_BASE[17:16]);
  assign unused_a_s = ^mem_a[31:18];

  // Classify this cycle's bus access; nothing happens while stalled or in reset.
  always_comb begin
    acc_s = ACC_NONE;
    if (rdy && !rst) begin
      if (io_sel_s) begin
        acc_s = mem_wr ? ACC_IO_WR : ACC_IO_RD;
      end else begin
        acc_s = mem_wr ? ACC_RAM_WR : ACC_RAM_RD;
      end
    end else begin
      acc_s = ACC_NONE;
    end
  end

  assign push_s = (acc_s == ACC_IO_WR) && (io_addr_s == IO_OUT);
  assign pop_s  = tx_valid && tx_ready;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (FIFO_PTR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .din         (mem_din),
    .pop         (pop_s),
    .dout        (tx_data),
    .full        (fifo_full_s),
    .almost_full (io_buffer_full),
    .count       (fifo_count_s)
  );

  assign tx_valid = (fifo_count_s != '0);

  // RAM write port; the preload strobe wins and works even during reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      ram_r[load_addr] <= load_data;
    end else if (acc_s == ACC_RAM_WR) begin
      ram_r[ram_idx_s] <= mem_din;
    end
  end

  // Registered read data; holds across writes and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_dout_r <= 8'h00;
    end else begin
      case (acc_s)
        ACC_RAM_RD: mem_dout_r <= ram_r[ram_idx_s];
        ACC_IO_RD:  mem_dout_r <= io_read_data(mem_a[17:0], halt_r);
        default:    mem_dout_r <= mem_dout_r;
      endcase
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if ((acc_s == ACC_IO_WR) && (io_addr_s == IO_HALT)) halt_r <= 1'b1;
      if (push_s && fifo_full_s && !pop_s) overflow_r <= 1'b1;
    end
  end

  assign mem_dout = mem_dout_r;
  assign halt     = halt_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench: stimulus pushes expected read bytes and TX bytes into
// queues; a monitor pops and compares whenever the DUT presents them.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_wr, load_en, tx_ready;
  logic [7:0]  mem_din, load_data, mem_dout, tx_data;
  logic [31:0] mem_a;
  logic [16:0] load_addr;
  logic        io_buffer_full, tx_valid, halt, overflow;
  logic        rd_tag;

  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_bus_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .halt(halt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: read data one cycle after its address; TX byte on each handshake.
  logic rd_pending = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rd_pending) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("mem_dout", {24'd0, mem_dout}, {24'd0, exp_rd.pop_front()});
    end
    rd_pending = rd_tag;
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    end
  end

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    @(negedge clk);
    mem_a = a; mem_wr = 1'b0; rd_tag = 1'b1;
    exp_rd.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    mem_wr = 1'b0; rd_tag = 1'b0; mem_a = 32'd0;
  endtask

  // Single-cycle write strobe followed by one idle cycle.
  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic r);
    @(negedge clk);
    mem_a = a; mem_din = d; mem_wr = 1'b1; rd_tag = 1'b0; rdy = r;
    @(negedge clk);
    mem_wr = 1'b0; rdy = 1'b1;
  endtask

  task automatic at_sample();
    #1;
  endtask

  initial begin
    logic [7:0] pre_d [5];
    logic [16:0] pre_a [5];
    bit done;
    pre_a = '{17'h0, 17'h1, 17'h2, 17'h3, 17'h101};
    pre_d = '{8'h13, 8'h02, 8'h00, 8'h00, 8'h77};
    rst = 1'b1; rdy = 1'b1; mem_wr = 1'b0; mem_a = 32'd0; mem_din = 8'd0;
    load_en = 1'b0; load_addr = 17'd0; load_data = 8'd0; tx_ready = 1'b0; rd_tag = 1'b0;

    // Preload while reset is held
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = pre_a[i]; load_data = pre_d[i];
    end
    @(negedge clk);
    load_en = 1'b0;
    at_sample();
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_buf_full", {31'd0, io_buffer_full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back reads of the preloaded program bytes
    rd(32'h0, 8'h13); rd(32'h1, 8'h02); rd(32'h2, 8'h00); rd(32'h3, 8'h00);
    idle();

    // Bus write then readback; stalled write must not land
    wr(32'h100, 8'hAB, 1'b1);
    rd(32'h100, 8'hAB);
    idle();
    wr(32'h101, 8'h55, 1'b0);
    rd(32'h101, 8'h77);
    idle();

    // "Hi" through the FIFO with the consumer ready
    tx_ready = 1'b1;
    exp_tx.push_back(8'h48); wr(32'h30000, 8'h48, 1'b1);
    exp_tx.push_back(8'h69); wr(32'h30000, 8'h69, 1'b1);
    idle(); idle();
    at_sample();
    check("hi_drained", {31'd0, tx_valid}, 32'd0);
    rd(32'h0, 8'h13);
    idle();

    // Fill with consumer stalled: almost-full after the 7th entry
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_tx.push_back(8'h10 + 8'(i));
      wr(32'h30000, 8'h10 + 8'(i), 1'b1);
      at_sample();
      if (i == 5) check("af_at6", {31'd0, io_buffer_full}, 32'd0);
    end
    check("af_at7", {31'd0, io_buffer_full}, 32'd1);
    exp_tx.push_back(8'h17); wr(32'h30000, 8'h17, 1'b1);
    at_sample();
    check("full_no_ovf", {31'd0, overflow}, 32'd0);

    // Push and pop together while full
    @(negedge clk);
    exp_tx.push_back(8'h18);
    mem_a = 32'h30000; mem_din = 8'h18; mem_wr = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    mem_wr = 1'b0; tx_ready = 1'b0;
    at_sample();
    check("pp_no_ovf", {31'd0, overflow}, 32'd0);
    check("pp_af", {31'd0, io_buffer_full}, 32'd1);

    // Ninth byte into a full FIFO is dropped
    wr(32'h30000, 8'h19, 1'b1);
    at_sample();
    check("ovf_set", {31'd0, overflow}, 32'd1);

    // Drain: almost-full stays at count 7, clears at 6
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk); at_sample();
    check("af_cnt7", {31'd0, io_buffer_full}, 32'd1);
    @(negedge clk); at_sample();
    check("af_cnt6", {31'd0, io_buffer_full}, 32'd0);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); at_sample();
      done = (exp_tx.size() == 0) && !tx_valid;
    end
    check("drain_done", {31'd0, done}, 32'd1);

    // Halt flag and IO readback
    check("halt_before", {31'd0, halt}, 32'd0);
    wr(32'h30004, 8'h00, 1'b1);
    at_sample();
    check("halt_set", {31'd0, halt}, 32'd1);
    rd(32'h30004, 8'h01); rd(32'h30008, 8'h00); rd(32'h30000, 8'h00);
    idle();

    // Reset mid-operation with a byte queued and a read in flight
    tx_ready = 1'b0;
    wr(32'h30000, 8'h5A, 1'b1);
    at_sample();
    check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
    @(negedge clk);
    mem_a = 32'h100; mem_wr = 1'b0; rst = 1'b1;
    @(negedge clk); at_sample();
    check("rst2_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst2_halt", {31'd0, halt}, 32'd0);
    check("rst2_overflow", {31'd0, overflow}, 32'd0);
    check("rst2_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h100, 8'hAB); rd(32'h0, 8'h13);
    idle(); idle();
    check("rd_queue_empty", exp_rd.size(), 32'd0);
    check("tx_queue_empty", exp_tx.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
